// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding initiator for the 16-bit address / 8-bit data target bus.
// Optional macro BUS_INITIATOR_RETRY_EN: re-issue a transaction once after its first timeout.
module bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          SPLIT_WRITE    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_rw,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] bus_addr_out,
  output logic        bus_addr_out_valid,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_out_valid,
  output logic        bus_rw,
  input  logic [7:0]  bus_data_in,
  input  logic        bus_data_in_valid,
  input  logic        bus_ack,
  input  logic        bus_target_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] bus_addr_out_q, bus_addr_out_d;
  logic [7:0]  bus_data_out_q, bus_data_out_d;
  logic        bus_rw_q, bus_rw_d;
  logic        bus_addr_out_valid_q, bus_addr_out_valid_d;
  logic        bus_data_out_valid_q, bus_data_out_valid_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic accept;
  logic timeout;
  logic retry_allowed;
  logic finish;

  assign req_ready = rst_n && (state_q == S_IDLE) && bus_target_ready;
  assign accept    = req_valid && req_ready;
  assign timeout   = (state_q == S_WAIT) && !bus_ack && (cnt_q == TIMEOUT_LAST);

`ifdef BUS_INITIATOR_RETRY_EN
  logic retry_q, retry_d;

  // Set by the first timeout of a transaction; only a second timeout reports an error.
  always_comb begin
    retry_d = retry_q;
    if (state_q == S_IDLE) begin
      retry_d = 1'b0;
    end else if (timeout && !retry_q) begin
      retry_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end

  assign retry_allowed = !retry_q;
`else
  assign retry_allowed = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= S_IDLE;
      cnt_q                <= '0;
      bus_addr_out_q       <= '0;
      bus_data_out_q       <= '0;
      bus_rw_q             <= 1'b0;
      bus_addr_out_valid_q <= 1'b0;
      bus_data_out_valid_q <= 1'b0;
      rsp_valid_q          <= 1'b0;
      rsp_rdata_q          <= '0;
      rsp_err_q            <= 1'b0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      bus_addr_out_q       <= bus_addr_out_d;
      bus_data_out_q       <= bus_data_out_d;
      bus_rw_q             <= bus_rw_d;
      bus_addr_out_valid_q <= bus_addr_out_valid_d;
      bus_data_out_valid_q <= bus_data_out_valid_d;
      rsp_valid_q          <= rsp_valid_d;
      rsp_rdata_q          <= rsp_rdata_d;
      rsp_err_q            <= rsp_err_d;
    end
  end

  // Next-state logic; an ack in the final WAIT cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_ADDR;
      S_ADDR: state_d = (bus_rw_q && SPLIT_WRITE) ? S_DATA : S_WAIT;
      S_DATA: state_d = S_WAIT;
      S_WAIT: begin
        if (bus_ack) begin
          state_d = S_RESP;
        end else if (timeout) begin
          state_d = retry_allowed ? S_ADDR : S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: every bus/response output is precomputed from the next state.
  always_comb begin
    bus_addr_out_d = bus_addr_out_q;
    bus_data_out_d = bus_data_out_q;
    bus_rw_d       = bus_rw_q;
    if (accept) begin
      bus_addr_out_d = req_addr;
      bus_data_out_d = req_wdata;
      bus_rw_d       = req_rw;
    end else if (state_d == S_IDLE) begin
      bus_addr_out_d = '0;
      bus_data_out_d = '0;
      bus_rw_d       = 1'b0;
    end

    cnt_d = cnt_q;
    if (state_q != S_WAIT) begin
      cnt_d = '0;
    end else if (!bus_ack) begin
      cnt_d = cnt_q + 8'd1;
    end

    bus_addr_out_valid_d = (state_d == S_ADDR);
    bus_data_out_valid_d = (state_d == S_DATA) ||
                           ((state_d == S_ADDR) && bus_rw_d && !SPLIT_WRITE);

    finish      = (state_q == S_WAIT) && (state_d == S_RESP);
    rsp_valid_d = (state_d == S_RESP);
    rsp_err_d   = finish && (!bus_ack || (!bus_rw_q && !bus_data_in_valid));
    rsp_rdata_d = (finish && bus_ack && !bus_rw_q && bus_data_in_valid) ? bus_data_in : 8'h00;
  end

  assign busy               = (state_q != S_IDLE);
  assign bus_addr_out       = bus_addr_out_q;
  assign bus_data_out       = bus_data_out_q;
  assign bus_rw             = bus_rw_q;
  assign bus_addr_out_valid = bus_addr_out_valid_q;
  assign bus_data_out_valid = bus_data_out_valid_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_err            = rsp_err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: two instances (non-split, TIMEOUT 16 / split, TIMEOUT 5)
// driven with directed and random transactions against a cycle-level outcome model.
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [15:0] req_addr [2];
  logic [7:0]  req_wdata [2];
  logic        req_rw [2];
  logic        rsp_valid [2];
  logic [7:0]  rsp_rdata [2];
  logic        rsp_err [2];
  logic        busy [2];
  logic [15:0] bus_addr_out [2];
  logic        bus_addr_out_valid [2];
  logic [7:0]  bus_data_out [2];
  logic        bus_data_out_valid [2];
  logic        bus_rw [2];
  logic [7:0]  bus_data_in [2];
  logic        bus_data_in_valid [2];
  logic        bus_ack [2];
  logic        bus_target_ready [2];

  int tests_run = 0;
  int tests_failed = 0;
  int txn_no = 0;

`ifdef BUS_INITIATOR_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      bus_initiator #(
        .TIMEOUT_CYCLES(gi == 0 ? 16 : 5),
        .SPLIT_WRITE   (gi == 1)
      ) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid[gi]),
        .req_ready         (req_ready[gi]),
        .req_addr          (req_addr[gi]),
        .req_wdata         (req_wdata[gi]),
        .req_rw            (req_rw[gi]),
        .rsp_valid         (rsp_valid[gi]),
        .rsp_rdata         (rsp_rdata[gi]),
        .rsp_err           (rsp_err[gi]),
        .busy              (busy[gi]),
        .bus_addr_out      (bus_addr_out[gi]),
        .bus_addr_out_valid(bus_addr_out_valid[gi]),
        .bus_data_out      (bus_data_out[gi]),
        .bus_data_out_valid(bus_data_out_valid[gi]),
        .bus_rw            (bus_rw[gi]),
        .bus_data_in       (bus_data_in[gi]),
        .bus_data_in_valid (bus_data_in_valid[gi]),
        .bus_ack           (bus_ack[gi]),
        .bus_target_ready  (bus_target_ready[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int to_of(input int inst);
    return (inst == 0) ? 16 : 5;
  endfunction

  task automatic check_all_zero(input int inst, input string tag);
    check({tag, "_req_ready"}, 32'(req_ready[inst]), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid[inst]), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata[inst]), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err[inst]), 32'd0);
    check({tag, "_busy"}, 32'(busy[inst]), 32'd0);
    check({tag, "_addr"}, 32'(bus_addr_out[inst]), 32'd0);
    check({tag, "_addr_v"}, 32'(bus_addr_out_valid[inst]), 32'd0);
    check({tag, "_data"}, 32'(bus_data_out[inst]), 32'd0);
    check({tag, "_data_v"}, 32'(bus_data_out_valid[inst]), 32'd0);
    check({tag, "_rw"}, 32'(bus_rw[inst]), 32'd0);
  endtask

  // Runs one transaction. ack_j is the WAIT-relative cycle of the target's ack;
  // ack_j >= timeout means the target never acks.
  task automatic run_txn(input int inst, input logic rw, input logic [15:0] addr,
                         input logic [7:0] wdata, input int ack_j, input logic dv,
                         input logic [7:0] rd, input bit gap);
    int to, pre, ws, resp_c, dcyc, acyc2, dcyc2;
    bit timed_out;
    logic [7:0] exp_rd;
    logic exp_err;
    to        = to_of(inst);
    pre       = (rw && inst == 1) ? 2 : 1;
    ws        = pre + 1;
    timed_out = (ack_j >= to);
    if (!timed_out) begin
      resp_c  = ws + ack_j + 1;
      exp_err = !rw && !dv;
      exp_rd  = (!rw && dv) ? rd : 8'h00;
    end else begin
      resp_c  = RETRY ? 2 * (pre + to) + 1 : pre + to + 1;
      exp_err = 1'b1;
      exp_rd  = 8'h00;
    end
    dcyc  = (inst == 1) ? 2 : 1;
    acyc2 = (timed_out && RETRY) ? pre + to + 1 : -100;
    dcyc2 = acyc2 + dcyc - 1;

    if (gap) begin
      @(negedge clk);
      req_valid[inst] = 1'b1;
      req_addr[inst] = addr;
      req_wdata[inst] = wdata;
      req_rw[inst] = rw;
      bus_target_ready[inst] = 1'b0;
      bus_ack[inst] = 1'b1;
      #1 check("ready_low_target_busy", 32'(req_ready[inst]), 32'd0);
      @(negedge clk);
      check("no_accept_target_busy", 32'(busy[inst]), 32'd0);
    end

    @(negedge clk);
    req_valid[inst] = 1'b1;
    req_addr[inst] = addr;
    req_wdata[inst] = wdata;
    req_rw[inst] = rw;
    bus_target_ready[inst] = 1'b1;
    bus_ack[inst] = 1'($urandom);
    bus_data_in_valid[inst] = 1'($urandom);
    bus_data_in[inst] = 8'($urandom);
    #1 check("ready_idle", 32'(req_ready[inst]), 32'd1);
    @(posedge clk);

    for (int c = 1; c <= resp_c + 1; c++) begin
      @(negedge clk);
      check("addr_strobe", 32'(bus_addr_out_valid[inst]), 32'(c == 1 || c == acyc2));
      check("data_strobe", 32'(bus_data_out_valid[inst]), 32'(rw && (c == dcyc || c == dcyc2)));
      check("rsp_valid", 32'(rsp_valid[inst]), 32'(c == resp_c));
      if (c == 1) begin
        check("bus_addr", 32'(bus_addr_out[inst]), 32'(addr));
        check("bus_rw", 32'(bus_rw[inst]), 32'(rw));
      end
      if (rw && c == dcyc) check("bus_data", 32'(bus_data_out[inst]), 32'(wdata));
      if (c == resp_c) begin
        check("rsp_rdata", 32'(rsp_rdata[inst]), 32'(exp_rd));
        check("rsp_err", 32'(rsp_err[inst]), 32'(exp_err));
      end
      if (c == resp_c + 1) begin
        check("rdata_clear", 32'(rsp_rdata[inst]), 32'd0);
        check("err_clear", 32'(rsp_err[inst]), 32'd0);
        check("busy_clear", 32'(busy[inst]), 32'd0);
        check("ready_after", 32'(req_ready[inst]), 32'd1);
      end
      // Request lines are scrambled after acceptance; the latched values must not move.
      req_valid[inst] = 1'b0;
      req_addr[inst] = 16'($urandom);
      req_wdata[inst] = 8'($urandom);
      req_rw[inst] = 1'($urandom);
      bus_target_ready[inst] = (c >= resp_c) ? 1'b1 : 1'($urandom);
      bus_data_in[inst] = 8'($urandom);
      if (!timed_out && c == ws + ack_j) begin
        bus_ack[inst] = 1'b1;
        bus_data_in_valid[inst] = dv;
        bus_data_in[inst] = rd;
      end else if (c < ws) begin
        bus_ack[inst] = 1'($urandom);
        bus_data_in_valid[inst] = 1'($urandom);
      end else begin
        bus_ack[inst] = 1'b0;
        bus_data_in_valid[inst] = 1'($urandom);
      end
    end
    bus_ack[inst] = 1'b0;
    bus_data_in_valid[inst] = 1'b0;
    txn_no++;
    $display("[TB] txn %0d inst %0d %s addr=%04h wdata=%02h ack_j=%0d dv=%0d -> rsp cycle %0d err=%0d rdata=%02h",
             txn_no, inst, rw ? "WR" : "RD", addr, wdata, ack_j, dv, resp_c, exp_err, exp_rd);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i] = '0;
      req_wdata[i] = '0;
      req_rw[i] = 1'b0;
      bus_data_in[i] = '0;
      bus_data_in_valid[i] = 1'b0;
      bus_ack[i] = 1'b0;
      bus_target_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_all_zero(0, "reset0");
    check_all_zero(1, "reset1");
    rst_n = 1'b1;

    // Directed cases
    run_txn(0, 1'b1, 16'h0005, 8'hA5, 0, 1'b0, 8'h00, 1'b0);
    run_txn(0, 1'b0, 16'h0005, 8'h00, 0, 1'b1, 8'hA5, 1'b0);
    run_txn(1, 1'b1, 16'h000A, 8'h3C, 0, 1'b0, 8'h00, 1'b0);
    run_txn(0, 1'b0, 16'h1234, 8'h00, 99, 1'b0, 8'h00, 1'b0);
    run_txn(0, 1'b0, 16'h4321, 8'h00, 15, 1'b1, 8'h5A, 1'b0);
    run_txn(0, 1'b0, 16'h0101, 8'h00, 3, 1'b0, 8'h77, 1'b1);
    run_txn(1, 1'b1, 16'hBEEF, 8'h11, 99, 1'b0, 8'h00, 1'b0);
    run_txn(1, 1'b0, 16'hCAFE, 8'h00, 4, 1'b1, 8'hC3, 1'b0);

    // Stray ack while idle
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stray_idle_rsp", 32'(rsp_valid[0]), 32'd0);
      check("stray_idle_busy", 32'(busy[0]), 32'd0);
      bus_ack[0] = 1'b1;
      bus_data_in_valid[0] = 1'b1;
      bus_data_in[0] = 8'($urandom);
    end
    @(negedge clk);
    check("stray_idle_rsp_end", 32'(rsp_valid[0]), 32'd0);
    bus_ack[0] = 1'b0;
    bus_data_in_valid[0] = 1'b0;

    // Reset in the middle of WAIT
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_rw[0] = 1'b0;
    req_addr[0] = 16'h5555;
    bus_target_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_reset", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero(0, "midreset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_reset", 32'(req_ready[0]), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("no_rsp_after_reset", 32'(rsp_valid[0]), 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int inst;
      inst = int'($urandom_range(0, 1));
      run_txn(inst, 1'($urandom), 16'($urandom), 8'($urandom),
              int'($urandom_range(0, to_of(inst) + 2)),
              ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
